// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder.
package serial_adder_pkg;

  // Controller states: waiting, shifting bits through the cell, result pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

endpackage

// File: rtl/fa.sv
// One-bit full-adder cell.
module fa (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one operand bit pair per clock through a single
// full-adder cell, LSB first, with a start/busy/done handshake. The result
// registers change only on entry to DONE (or reset) and hold otherwise.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  import serial_adder_pkg::*;

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  sa_state_t        state_r;
  sa_state_t        state_s;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] s_sr_r;
  logic             carry_r;
  logic [CNT_W-1:0] cnt_r;
  logic             fa_s_s;
  logic             fa_cout_s;
  logic [WIDTH-1:0] s_next_s;
  logic             last_bit_s;

  // The only adder: the current LSBs plus the carry held from the previous bit.
  fa u_fa (
    .A    (a_sr_r[0]),
    .B    (b_sr_r[0]),
    .Cin  (carry_r),
    .S    (fa_s_s),
    .Cout (fa_cout_s)
  );

  assign last_bit_s = (cnt_r == LAST_BIT);

  // New sum bit enters at the MSB; written this way so WIDTH=1 needs no special case.
  always_comb begin
    s_next_s           = s_sr_r >> 1;
    s_next_s[WIDTH-1]  = fa_s_s;
  end

  // Next-state decode; start is only looked at in IDLE and DONE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        if (last_bit_s) state_s = DONE;
        else            state_s = RUN;
      end
      DONE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Datapath: operand capture, bit shifting, result latch and registered status.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_sr_r  <= {WIDTH{1'b0}};
      b_sr_r  <= {WIDTH{1'b0}};
      s_sr_r  <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      sum     <= {WIDTH{1'b0}};
      cout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            a_sr_r  <= a;
            b_sr_r  <= b;
            carry_r <= cin;
            cnt_r   <= {CNT_W{1'b0}};
          end
        end
        RUN: begin
          s_sr_r  <= s_next_s;
          carry_r <= fa_cout_s;
          a_sr_r  <= a_sr_r >> 1;
          b_sr_r  <= b_sr_r >> 1;
          cnt_r   <= cnt_r + CNT_W'(1);
          if (last_bit_s) begin
            sum  <= s_next_s;
            cout <= fa_cout_s;
          end
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
      busy <= (state_s == RUN);
      done <= (state_s == DONE);
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Randomised scoreboard bench for serial_adder (WIDTH=8).
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         n_rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  typedef struct {
    int       acc;   // edge at which start is accepted
    int       due;   // edge at which done must appear
    logic [W:0] res; // {cout, sum}
  } exp_t;

  exp_t       q[$];
  logic [W:0] last_res;
  int         cyc;
  int         free_at;
  int         n_checks;
  int         n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges; after edge k, cyc == k.
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s at edge %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: on every falling edge compare status and result against the scoreboard.
  always @(negedge clk) begin
    logic exp_busy;
    logic exp_done;
    int   k;
    k = cyc;
    exp_busy = (q.size() > 0) && (q[0].acc <= k) && (k < q[0].due);
    exp_done = (q.size() > 0) && (q[0].due == k);
    check("busy", {31'd0, busy}, {31'd0, exp_busy});
    check("done", {31'd0, done}, {31'd0, exp_done});
    if (exp_done) begin
      last_res = q[0].res;
      void'(q.pop_front());
    end
    check("result", {23'd0, cout, sum}, {23'd0, last_res});
  end

  // Drive one cycle of inputs; record an accepted add in the scoreboard.
  task automatic drive(input logic st, input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    exp_t e;
    int   nxt;
    @(negedge clk);
    #1;
    start = st;
    a     = av;
    b     = bv;
    cin   = cv;
    nxt   = cyc + 1;
    if (st && n_rst && nxt >= free_at) begin
      e.acc   = nxt;
      e.due   = nxt + W;
      e.res   = (W+1)'(av) + (W+1)'(bv) + (W+1)'(cv);
      free_at = nxt + W + 1;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, W'($urandom), W'($urandom), 1'($urandom));
  endtask

  task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    drive(1'b1, av, bv, cv);
    idle(W + 2);
  endtask

  // Asynchronous reset dropped between edges; outputs must clear immediately.
  task automatic do_reset(input int hold);
    @(negedge clk);
    #1;
    n_rst = 1'b0;
    start = 1'b0;
    q.delete();
    last_res = '0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum",  {24'd0, sum},  32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1;
      start = 1'($urandom);
      a     = W'($urandom);
      b     = W'($urandom);
      cin   = 1'($urandom);
    end
    @(negedge clk);
    #1;
    start   = 1'b0;
    n_rst   = 1'b1;
    free_at = cyc + 1;
  endtask

  initial begin
    cyc      = 0;
    free_at  = 0;
    n_checks = 0;
    n_fail   = 0;
    last_res = '0;
    n_rst    = 1'b0;
    start    = 1'($urandom);
    a        = W'($urandom);
    b        = W'($urandom);
    cin      = 1'($urandom);

    // Reset held for two cycles with random inputs.
    do_reset(2);
    idle(2);

    // Directed adds, including carry-out and all-ones with carry-in.
    op(8'h5A, 8'h33, 1'b0);
    op(8'hFF, 8'h01, 1'b0);
    op(8'hFF, 8'hFF, 1'b1);

    // Start pulse with new operands mid-run must be ignored.
    drive(1'b1, 8'h12, 8'h34, 1'b0);
    idle(2);
    drive(1'b1, 8'hAA, 8'hBB, 1'b1);
    idle(W + 2);

    // Start held high: back-to-back adds with no IDLE cycle.
    drive(1'b1, 8'h01, 8'h02, 1'b0);
    for (int i = 0; i < W + 1; i++) drive(1'b1, 8'h10, 8'h20, 1'b0);
    idle(W + 2);

    // Reset mid-add aborts it, then a fresh add completes normally.
    drive(1'b1, 8'h77, 8'h66, 1'b1);
    idle(3);
    do_reset(1);
    op(8'hC3, 8'h3C, 1'b1);

    // Random traffic with random start density and operand churn.
    for (int i = 0; i < 400; i++)
      drive(($urandom_range(0, 3) == 0), W'($urandom), W'($urandom), 1'($urandom));

    // Drain outstanding adds within a bounded number of cycles.
    for (int i = 0; i < 3 * W && q.size() > 0; i++) idle(1);
    if (q.size() > 0) begin
      n_checks = n_checks + 1;
      n_fail   = n_fail + 1;
      $display("FAIL drain: %0d adds still pending, expected 0", q.size());
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder built around the existing one-bit `fa` full-adder cell. It feeds `fa` one operand bit pair per clock, LSB first, and registers the carry between cycles. It collects the sum bits and presents the registered result with a start/busy/done handshake. It sits directly upstream of `fa` and consumes its `S`/`Cout`. Game logic, such as score update, uses it to add values without a WIDTH-bit combinational adder.

## Interface
Parameters:
- `WIDTH`, 8, operand and sum width in bits; legal range is ≥ 1.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request an add; sampled only in IDLE or DONE.
- `a`  in  WIDTH  operand A; captured on an accepted `start`.
- `b`  in  WIDTH  operand B; captured on an accepted `start`.
- `cin`  in  1  carry-in; captured on an accepted `start`.
- `busy`  out  1  high while an add is in progress (RUN).
- `done`  out  1  one-cycle pulse; `sum`/`cout` became valid this cycle.
- `sum`  out  WIDTH  registered result of `a + b + cin`, modulo 2^WIDTH.
- `cout`  out  1  registered carry-out of the MSB.

## Operation
- The state machine has three states: IDLE, RUN and DONE.
- Internal registers:
  - `a_sr`, `b_sr`: right-shifting operand registers.
  - `s_sr`: sum shift register; new bits shift in at the MSB.
  - `carry`: registered carry between bit cycles.
  - `cnt`: bit counter, `$clog2(WIDTH+1)` bits.
- IDLE or DONE with `start`=1 → RUN:
  - load `a_sr`←`a`, `b_sr`←`b`, `carry`←`cin`, `cnt`←0.
- IDLE with `start`=0 → IDLE. DONE with `start`=0 → IDLE.
- RUN, on each edge:
  - `fa` inputs are `a_sr[0]`, `b_sr[0]` and `carry`.
  - `s_sr` ← {`S`, `s_sr[WIDTH-1:1]`}; `carry` ← `Cout`.
  - `a_sr` and `b_sr` shift right by one; `cnt`++.
- RUN with `cnt`==WIDTH-1 (last bit) → DONE, and on the same edge:
  - `sum` ← {`S`, `s_sr[WIDTH-1:1]`}; `cout` ← `Cout`.
- `busy` = (state==RUN). `done` = (state==DONE).
- `sum` and `cout` change only on entry to DONE and on reset. They hold the last result through IDLE and through a following RUN.
- `start` during RUN is ignored and does not perturb the operation in flight.
- Operands are captured at accept time. Changes on `a`, `b` or `cin` afterward have no effect.
- WIDTH=1: RUN lasts exactly one cycle.

## Timing
- Reset (`n_rst`=0), asynchronous and immediate:
  - state ← IDLE.
  - `busy`=0, `done`=0, `sum`=0, `cout`=0.
  - all internal registers ← 0.
- Reset asserted mid-RUN aborts the add. No `done` is produced.
- Timing for a `start` accepted at edge 0:
  - `busy`=1 from edge 0 to edge WIDTH.
  - `done`=1 and the result is visible from edge WIDTH to edge WIDTH+1.
- Latency: WIDTH+1 clocks from the `start` sample to the end of the `done` pulse.
- Back-to-back: `start` held high in DONE is accepted at edge WIDTH+1. There is no IDLE cycle between operations. Throughput is one add per WIDTH+1 clocks.
- `start` held high continuously therefore re-triggers after every `done`.

## Structure
- `serial_adder_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t`.
- One sub-module: a single instance of the existing `fa` cell. The adder's own bit logic contains no other combinational adder.
- The next-state logic and the registered datapath are kept in separate processes.

## Test plan
- Reset: hold `n_rst`=0 for 2 cycles with random inputs → `busy`=0, `done`=0, `sum`=0, `cout`=0 throughout.
- WIDTH=8, `a`=8'h5A, `b`=8'h33, `cin`=0, start at edge 0 → `busy` over edges 0..8; `done` pulses at edge 8 with `sum`=8'h8D, `cout`=0.
- `a`=8'hFF, `b`=8'h01, `cin`=0 → `sum`=8'h00, `cout`=1. Then `a`=8'hFF, `b`=8'hFF, `cin`=1 → `sum`=8'hFF, `cout`=1.
- Change `a`/`b` and pulse `start` at edge 3 during RUN → ignored; result is from the first operands; `done` still at edge 8.
- Hold `start` high with two operand sets (8'h01+8'h02, then 8'h10+8'h20) → first `done` at edge 8 with `sum`=8'h03. Second is accepted at edge 9; second `done` at edge 17 with `sum`=8'h30. `busy` is low only during the DONE cycles.
- Drop `n_rst` at edge 4 of an add → outputs zero immediately and no `done`. A new `start` after release completes normally with correct `sum`.
